x25519_mult_squeeze: RTL

//  Downstream consumer of the X25519 multiply pass pipeline. Collects the 32 per-limb 32-bit column sums
//  (issued in order i=0..31) into a holding register, then carry-propagates them into canonical 8-bit

---
 rtl/x25519_mult_squeeze_pkg.sv | 22 ++
 rtl/x25519_mult_squeeze.sv | 134 +++++++++++++
 2 files changed

// File: rtl/x25519_mult_squeeze_pkg.sv
// Shared types and constants for the X25519 multiply-pass squeeze stage.
package x25519_mult_squeeze_pkg;

  localparam int         X25519_LIMBS    = 32;
  localparam logic [6:0] X25519_TOP_MASK = 7'h7f;
  localparam int         X25519_FOLD     = 19;

  // Canonical field element: 32 limbs of 8 bits, limb 0 in the low byte.
  typedef logic [X25519_LIMBS-1:0][7:0]  bignum_t;
  // Unreduced column sums / holding register: 32 limbs of 32 bits.
  typedef logic [X25519_LIMBS-1:0][31:0] bignum32_t;

  // Keep the low byte of every wide limb.
  function automatic bignum_t narrow_limbs(input bignum32_t wide);
    bignum_t res;
    for (int i = 0; i < X25519_LIMBS; i++) begin
      res[i] = wide[i][7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/x25519_mult_squeeze.sv
// Collects 32 column sums from the multiply pass and squeezes them into
// 8-bit limbs with two carry passes (partial reduction mod 2^255-19).
module x25519_mult_squeeze
  import x25519_mult_squeeze_pkg::*;
#(
  parameter int ACC_WIDTH = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         busy,
  output logic         out_valid,
  output logic [255:0] out,
  output logic         err
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_PASS1   = 2'd1;
  localparam logic [1:0] ST_PASS2   = 2'd2;

  logic [1:0]           state;
  logic [4:0]           count;
  logic [4:0]           j;
  logic                 flush;      // PASS2 finished; next cycle publishes the result
  logic [ACC_WIDTH-1:0] u;
  bignum32_t            tmp;

  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] u_next;
  logic                 wr_en;
  logic [4:0]           wr_idx;
  logic [31:0]          wr_data;

  // Multiply by 19 with shifts and adds: 16x + 2x + x.
  function automatic logic [ACC_WIDTH-1:0] times_fold(input logic [ACC_WIDTH-1:0] x);
    return (x << 4) + (x << 1) + x;
  endfunction

  // One carry step on limb j plus the single write port of the holding register.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    sum     = u + ACC_WIDTH'(tmp[j]);
    u_next  = sum >> 8;
    wr_en   = 1'b0;
    wr_idx  = j;
    wr_data = {24'd0, sum[7:0]};
    case (state)
      ST_COLLECT: begin
        wr_en   = in_valid;
        wr_idx  = count;
        wr_data = in_data;
      end
      ST_PASS1: begin
        wr_en = 1'b1;
        if (j == 5'd31) begin
          wr_data = {25'd0, sum[6:0] & X25519_TOP_MASK};
          u_next  = times_fold(sum >> 7);
        end
      end
      ST_PASS2: begin
        wr_en = !flush;
        if (j == 5'd31) begin
          wr_data = sum[31:0];
        end
      end
      default: ;
    endcase
  end

  // Sequencer, accumulator, holding register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_COLLECT;
      count     <= '0;
      j         <= '0;
      flush     <= 1'b0;
      u         <= '0;
      // NOTE: the holding register is cleared too, so an aborted operation leaves no stale limbs behind.
      tmp       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read above sees the pre-edge values.
      out_valid <= 1'b0;
      err       <= 1'b0;
      if (wr_en) begin
        tmp[wr_idx] <= wr_data;
      end
      case (state)
        ST_COLLECT: begin
          if (in_valid) begin
            count <= count + 5'd1;
            busy  <= 1'b1;
            if (count == 5'd31) begin
              state <= ST_PASS1;
              j     <= '0;
              u     <= '0;
            end
          end else begin
            busy <= (count != 5'd0);
          end
        end
        ST_PASS1: begin
          err <= in_valid;
          u   <= u_next;
          j   <= j + 5'd1;
          if (j == 5'd31) begin
            state <= ST_PASS2;
          end
        end
        ST_PASS2: begin
          err <= in_valid;
          if (flush) begin
            out       <= narrow_limbs(tmp);
            out_valid <= 1'b1;
            flush     <= 1'b0;
            state     <= ST_COLLECT;
          end else begin
            u <= u_next;
            j <= j + 5'd1;
            if (j == 5'd31) begin
              flush <= 1'b1;
            end
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule
